// File: rtl/frogger_pkg.sv
// Shared grid geometry, timing constants, direction codes and FSM states for
// the frog movement logic.
package frogger_pkg;

   localparam int GRID_COLS    = 20;
   localparam int GRID_ROWS    = 15;
   localparam int TILE_PX      = 32;
   localparam int START_COL    = 10;
   localparam int START_ROW    = 14;
   localparam int REPEAT_DELAY = 30;
   localparam int REPEAT_RATE  = 8;
   localparam int MAX_LEVEL    = 9;

   localparam int COL_W  = 5;
   localparam int ROW_W  = 4;
   localparam int LVL_W  = 4;
   localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
   localparam int RATE_W = $clog2(REPEAT_RATE);

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic {
      ST_PLAY = 1'b0,
      ST_GOAL = 1'b1
   } state_e;

endpackage

// File: rtl/frog_key_repeat.sv
// One switch: rising-edge detect plus a frame-tick hold counter that issues
// auto-repeat requests after an initial delay and then at a fixed rate.
module frog_key_repeat
   import frogger_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   input  logic frame_tick,
   output logic req
);

   logic              key_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic [RATE_W-1:0] rate_cnt;
   logic              delay_hit;
   logic              rate_hit;
   logic              held_full;

   assign held_full = (hold_cnt == HOLD_W'(REPEAT_DELAY));
   assign delay_hit = frame_tick && key && (hold_cnt == HOLD_W'(REPEAT_DELAY - 1));
   assign rate_hit  = frame_tick && key && held_full && (rate_cnt == RATE_W'(REPEAT_RATE - 1));
   assign req       = (key && !key_q) || delay_hit || rate_hit;

   // History loads the live switch during reset so a key held across release
   // is not seen as a fresh press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_q    <= key;
         hold_cnt <= '0;
         rate_cnt <= '0;
      end else begin
         key_q <= key;
         if (!key) begin
            hold_cnt <= '0;
            rate_cnt <= '0;
         end else if (frame_tick) begin
            if (!held_full) begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end else if (rate_hit) begin
               rate_cnt <= '0;
            end else begin
               rate_cnt <= rate_cnt + RATE_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/frog_move_ctrl.sv
// Frame-synchronous frog movement: request priority, one-entry pending move,
// edge clamping, collision respawn and PLAY/GOAL level FSM.
module frog_move_ctrl
   import frogger_pkg::*;
(
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_Switch_1,
   input  logic             i_Switch_2,
   input  logic             i_Switch_3,
   input  logic             i_Switch_4,
   input  logic             i_Frame_Tick,
   input  logic             i_Collision,
   output logic [COL_W-1:0] o_Frog_Col,
   output logic [ROW_W-1:0] o_Frog_Row,
   output logic [LVL_W-1:0] o_Level,
   output logic             o_Move_Pulse,
   output logic             o_Level_Up
);

   logic [3:0]       req;
   logic             req_vld;
   dir_e             req_dir;

   state_e           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d, nxt_col;
   logic [ROW_W-1:0] row_q, row_d, nxt_row;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             pend_vld_q, pend_vld_d;
   dir_e             pend_dir_q, pend_dir_d;
   logic             coll_q, coll_d;
   logic             move_q, move_d;
   logic             lvl_up_q, lvl_up_d;
   logic             moved;

   frog_key_repeat u_key_left  (.clk(i_Clk), .rst_n(i_Rst_L), .key(i_Switch_1), .frame_tick(i_Frame_Tick), .req(req[0]));
   frog_key_repeat u_key_down  (.clk(i_Clk), .rst_n(i_Rst_L), .key(i_Switch_2), .frame_tick(i_Frame_Tick), .req(req[1]));
   frog_key_repeat u_key_up    (.clk(i_Clk), .rst_n(i_Rst_L), .key(i_Switch_3), .frame_tick(i_Frame_Tick), .req(req[2]));
   frog_key_repeat u_key_right (.clk(i_Clk), .rst_n(i_Rst_L), .key(i_Switch_4), .frame_tick(i_Frame_Tick), .req(req[3]));

   // Later assignments win: up > down > left > right.
   always_comb begin
      req_vld = |req;
      req_dir = DIR_RIGHT;
      if (req[0]) req_dir = DIR_LEFT;
      if (req[1]) req_dir = DIR_DOWN;
      if (req[2]) req_dir = DIR_UP;
   end

   // Clamped target of the pending move; decrements are guarded before subtracting.
   always_comb begin
      nxt_col = col_q;
      nxt_row = row_q;
      case (pend_dir_q)
         DIR_UP:    if (row_q != '0) nxt_row = row_q - ROW_W'(1);
         DIR_DOWN:  if (row_q != ROW_W'(GRID_ROWS - 1)) nxt_row = row_q + ROW_W'(1);
         DIR_LEFT:  if (col_q != '0) nxt_col = col_q - COL_W'(1);
         DIR_RIGHT: if (col_q != COL_W'(GRID_COLS - 1)) nxt_col = col_q + COL_W'(1);
         default:   ;
      endcase
   end

   assign moved = pend_vld_q && ((nxt_col != col_q) || (nxt_row != row_q));

   // NOTE: every signal gets a default first so this block cannot infer latches.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      lvl_d      = lvl_q;
      pend_vld_d = pend_vld_q && (state_q == ST_PLAY);
      pend_dir_d = pend_dir_q;
      coll_d     = coll_q || i_Collision;
      move_d     = 1'b0;
      lvl_up_d   = 1'b0;

      if (i_Frame_Tick) begin
         coll_d     = 1'b0;
         pend_vld_d = 1'b0;
         if (coll_q || i_Collision) begin
            col_d   = COL_W'(START_COL);
            row_d   = ROW_W'(START_ROW);
            state_d = ST_PLAY;
         end else if (state_q == ST_GOAL) begin
            col_d    = COL_W'(START_COL);
            row_d    = ROW_W'(START_ROW);
            lvl_d    = (lvl_q == LVL_W'(MAX_LEVEL)) ? '0 : lvl_q + LVL_W'(1);
            lvl_up_d = 1'b1;
            state_d  = ST_PLAY;
         end else if (moved) begin
            col_d  = nxt_col;
            row_d  = nxt_row;
            move_d = 1'b1;
            if (nxt_row == '0) state_d = ST_GOAL;
         end
      end

      // A request on the tick cycle waits for the next tick; GOAL discards requests.
      if (req_vld && (state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
         pend_vld_d = 1'b1;
         pend_dir_d = req_dir;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q    <= ST_PLAY;
         col_q      <= COL_W'(START_COL);
         row_q      <= ROW_W'(START_ROW);
         lvl_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_dir_q <= DIR_UP;
         coll_q     <= 1'b0;
         move_q     <= 1'b0;
         lvl_up_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         lvl_q      <= lvl_d;
         pend_vld_q <= pend_vld_d;
         pend_dir_q <= pend_dir_d;
         coll_q     <= coll_d;
         move_q     <= move_d;
         lvl_up_q   <= lvl_up_d;
      end
   end

   assign o_Frog_Col   = col_q;
   assign o_Frog_Row   = row_q;
   assign o_Level      = lvl_q;
   assign o_Move_Pulse = move_q;
   assign o_Level_Up   = lvl_up_q;

endmodule
